add32_sched: RTL
================

ADD32_SCHED -- requirements
Module: add32_sched

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters sharing the adder (legal range 2..8).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port req_valid  input  NREQ  per-requester operand valid.
REQ-005 SHALL provide port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-006 SHALL provide port req_a  input  32*NREQ  addend A; requester i occupies bits [32i+31:32i].
REQ-007 SHALL provide port req_b  input  32*NREQ  addend B; same packing as req_a.
REQ-008 SHALL provide port req_last  input  NREQ  marks the final word of a multi-word add.
REQ-009 SHALL provide port rsp_valid  output  1  result valid.
REQ-010 SHALL provide port rsp_ready  input  1  downstream accept.
REQ-011 SHALL provide port rsp_sum  output  32  sum bits [31:0].
REQ-012 SHALL provide port rsp_cout  output  1  carry out of bit 31.
REQ-013 SHALL provide port rsp_id  output  3  index of the requester that owns the result.
REQ-014 SHALL provide port rsp_last  output  1  copy of req_last for the accepted word.

Function
REQ-015 SHALL contain one shared 32-bit adder: {cout,sum} = a + b + cin, modulo 2^33, no saturation.
REQ-016 SHALL transfer a word from requester i when req_valid[i] & req_ready[i] are both high at a clock edge.
REQ-017 SHALL hold a one-entry output register; the output is "free" when rsp_valid=0 or rsp_ready=1 in the same cycle.
REQ-018 SHALL drive req_ready low for all requesters when the output is not free.
REQ-019 SHALL, in state ARB, grant the first requester with req_valid high, searching round-robin from index (last_grant+1) mod NREQ.
REQ-020 SHALL update last_grant only on a completed transfer.
REQ-021 SHALL register sum, cout, id and last, and raise rsp_valid, on the edge after a transfer (latency 1 cycle).
REQ-022 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-023 SHALL clear rsp_valid on an edge where rsp_ready=1 and no new transfer occurs; a simultaneous drain and transfer SHALL load the new result with rsp_valid staying high (full throughput, 1 word/cycle).
REQ-024 SHALL keep req_ready independent of rsp_* data values and free of combinational paths from req_a/req_b.
REQ-025 SHALL have states ARB and LOCK; ARB->LOCK on a transfer with req_last=0; LOCK->ARB on a transfer from the locked requester with req_last=1.
REQ-026 SHALL, in LOCK, grant only the locked requester; other requesters stall regardless of round-robin order.
REQ-027 SHALL use cin=0 for a word accepted in ARB and cin=stored carry for a word accepted in LOCK; the stored carry SHALL be updated with cout on every transfer.
REQ-028 SHALL treat a word with req_last=1 accepted in ARB as a single-word add (cin=0, remain in ARB).

Reset
REQ-029 SHALL, while rst=1, force rsp_valid=0, req_ready=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0, state=ARB, carry=0, last_grant=NREQ-1 (requester 0 is first priority).
REQ-030 SHALL abandon any chain in progress on reset; the pending output word SHALL be discarded.

Configuration
REQ-031 SHALL, with macro ADD32_SCHED_CARRY_CHAIN_EN defined, implement LOCK state and carry chaining per REQ-025..REQ-028.
REQ-032 SHALL, without ADD32_SCHED_CARRY_CHAIN_EN, omit LOCK and the carry register, use cin=0 always, ignore req_last, and drive rsp_last=1 on every result.

Verification
REQ-033 Single add: req0 A=0xFFFFFFFF B=0x00000001 last=1, rsp_ready=1 -> next cycle rsp_sum=0x00000000, rsp_cout=1, rsp_id=0, rsp_last=1.
REQ-034 Round robin: all 4 requesters valid continuously, single-word, rsp_ready=1 -> grant order 0,1,2,3,0,... one result per cycle.
REQ-035 Chain (macro on): req2 sends {A=0xFFFFFFFF,B=1,last=0} then {A=0,B=0,last=1} while req1 valid -> sums 0x00000000 cout=1, then 0x00000001 cout=0; req1 granted only after the second word.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles with result pending -> all req_ready=0, rsp_* unchanged; on rsp_ready=1 with req3 valid -> drain and new accept in the same cycle.
REQ-037 Reset mid-chain: rst=1 one cycle after a last=0 word -> rsp_valid=0, state ARB; next word from any requester uses cin=0.
REQ-038 Macro off: repeat REQ-035 stimulus -> second sum 0x00000000, rsp_last=1 on both, req1 may be granted between words.

Source files
------------

// File: rtl/add32_sched.sv
// ----------------------------------------------------------------------------
// add32_sched
//   Shares one 32-bit adder among NREQ requesters. A round-robin arbiter picks
//   one valid requester per cycle and presents its operands to the adder. The
//   result lands in a one-entry output register one cycle later. While a
//   downstream accept drains that register, a new word can be accepted in the
//   same cycle, so the block sustains one word per cycle.
//
//   Optional feature (macro ADD32_SCHED_CARRY_CHAIN_EN):
//     defined   : multi-word adds. A word with req_last=0 locks the arbiter
//                 to its requester (state LOCK). Later words in the chain use
//                 the stored carry as carry-in. The word with req_last=1
//                 releases the lock.
//     undefined : every word is a single add with cin=0. req_last is ignored
//                 and rsp_last is always 1.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous active-high reset
//   req_valid  : [NREQ] operand valid per requester
//   req_ready  : [NREQ] accept per requester; at most one bit is high
//   req_a      : [32*NREQ] addend A; requester i uses bits [32i+31:32i]
//   req_b      : [32*NREQ] addend B; packed the same way as req_a
//   req_last   : [NREQ] marks the final word of a multi-word add
//   rsp_valid  : result valid
//   rsp_ready  : downstream accept
//   rsp_sum    : sum bits [31:0]
//   rsp_cout   : carry out of bit 31
//   rsp_id     : index of the requester that owns the result
//   rsp_last   : req_last of the accepted word
// ----------------------------------------------------------------------------
module add32_sched #(
   parameter int NREQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]    req_last,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_sum,
   output logic               rsp_cout,
   output logic [2:0]         rsp_id,
   output logic               rsp_last
);

   localparam logic [2:0] LAST_GRANT_INIT = 3'(NREQ - 1);

`ifdef ADD32_SCHED_CARRY_CHAIN_EN
   typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;
   state_t state_q, state_d;
   logic   carry_q, carry_d;
`else
   // req_last has no function when chaining is compiled out
   logic   unused_last_s;
   assign  unused_last_s = ^req_last;
`endif

   logic            out_free_s;
   logic            gnt_found_s;
   logic [2:0]      gnt_idx_s;
   logic [NREQ-1:0] ready_s;
   logic            xfer_s;
   logic [31:0]     a_s, b_s, sum_s;
   logic            cin_s, cout_s, last_s;

   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_sum_q, rsp_sum_d;
   logic            rsp_cout_q, rsp_cout_d;
   logic [2:0]      rsp_id_q, rsp_id_d;
   logic            rsp_last_q, rsp_last_d;
   logic [2:0]      last_grant_q, last_grant_d;

   // Grant selection: locked requester in LOCK, otherwise round robin after last_grant
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = 3'd0;
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
      if (state_q == LOCK) begin
         // The locked requester is always the one granted last
         gnt_found_s = 1'b1;
         gnt_idx_s   = last_grant_q;
      end else begin
`endif
         // First pass covers indices above last_grant, second wraps to 0..last_grant
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_s && req_valid[i] && (3'(i) > last_grant_q)) begin
               gnt_found_s = 1'b1;
               gnt_idx_s   = 3'(i);
            end else begin
               gnt_found_s = gnt_found_s;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_s && req_valid[i] && (3'(i) <= last_grant_q)) begin
               gnt_found_s = 1'b1;
               gnt_idx_s   = 3'(i);
            end else begin
               gnt_found_s = gnt_found_s;
            end
         end
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
      end
`endif
   end

   // Ready decode and operand mux; ready depends only on valid, state and output occupancy
   always_comb begin
      out_free_s = !rsp_valid_q || rsp_ready;
      ready_s    = '0;
      a_s        = 32'd0;
      b_s        = 32'd0;
      last_s     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx_s == 3'(i)) begin
            ready_s[i] = out_free_s && gnt_found_s && !rst;
            a_s        = req_a[32*i +: 32];
            b_s        = req_b[32*i +: 32];
            last_s     = req_last[i];
         end else begin
            ready_s[i] = 1'b0;
         end
      end
      xfer_s = |(req_valid & ready_s);
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
      cin_s  = (state_q == LOCK) ? carry_q : 1'b0;
`else
      cin_s  = 1'b0;
`endif
      {cout_s, sum_s} = {1'b0, a_s} + {1'b0, b_s} + {32'd0, cin_s};
   end

   assign req_ready = ready_s;

   // Next-state: load a new result on transfer, otherwise drain or hold the output
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_sum_d    = rsp_sum_q;
      rsp_cout_d   = rsp_cout_q;
      rsp_id_d     = rsp_id_q;
      rsp_last_d   = rsp_last_q;
      last_grant_d = last_grant_q;
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
      state_d      = state_q;
      carry_d      = carry_q;
`endif
      if (xfer_s) begin
         rsp_valid_d  = 1'b1;
         rsp_sum_d    = sum_s;
         rsp_cout_d   = cout_s;
         rsp_id_d     = gnt_idx_s;
         last_grant_d = gnt_idx_s;
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
         rsp_last_d   = last_s;
         carry_d      = cout_s;
         // A last word always ends in ARB; any other word opens or continues a chain
         state_d      = last_s ? ARB : LOCK;
`else
         rsp_last_d   = 1'b1;
`endif
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end else begin
         rsp_valid_d  = rsp_valid_q;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_sum_q    <= 32'd0;
         rsp_cout_q   <= 1'b0;
         rsp_id_q     <= 3'd0;
         rsp_last_q   <= 1'b0;
         last_grant_q <= LAST_GRANT_INIT;
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
         state_q      <= ARB;
         carry_q      <= 1'b0;
`endif
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_sum_q    <= rsp_sum_d;
         rsp_cout_q   <= rsp_cout_d;
         rsp_id_q     <= rsp_id_d;
         rsp_last_q   <= rsp_last_d;
         last_grant_q <= last_grant_d;
`ifdef ADD32_SCHED_CARRY_CHAIN_EN
         state_q      <= state_d;
         carry_q      <= carry_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_last  = rsp_last_q;

endmodule
